gf180mcu_osu_sc_12t_lshifdn_hsrx: RTL and testbench

GF180MCU_OSU_SC_12T_LSHIFDN_HSRX -- requirements
Module: gf180mcu_osu_sc_12T_lshifdn_hsrx

---
 rtl/gf180mcu_osu_sc_12t_lshifdn_hsrx.sv | 122 ++++++++++++
 tb/tb_gf180mcu_osu_sc_12t_lshifdn_hsrx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_osu_sc_12t_lshifdn_hsrx.sv
// 4-phase REQ/ACK receiver from a level-shifted-down domain: REQ synchronized and glitch-filtered, D captured on accepted rise.
// Latency SYNC_STAGES+FILT from REQ to VALID, 1 cycle READY->ACK; holds VALID/Q until READY, never drops data.
module gf180mcu_osu_sc_12t_lshifdn_hsrx #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT        = 2
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             REQ,
   input  logic [WIDTH-1:0] D,
   output logic             ACK,
   output logic             VALID,
   input  logic             READY,
   output logic [WIDTH-1:0] Q,
   output logic             ABORT
);

   typedef enum logic [1:0] {IDLE, HOLD, ACKH} state_t;

   localparam logic [3:0] FILT_L = 4'(FILT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   logic                   reqf_q, reqf_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [3:0]             cnt_inc;
   logic                   reqf_rise;

   state_t                 state_q, state_d;
   logic                   valid_q, valid_d;
   logic                   ack_q, ack_d;
   logic                   abort_q, abort_d;
   logic [WIDTH-1:0]       q_q, q_d;

   assign req_s = sync_q[SYNC_STAGES-1];

   // A level change is accepted on the edge that sees its FILT-th consecutive sample,
   // so the FSM reacts to reqf_d rather than waiting a further cycle for reqf_q.
   always_comb begin
      cnt_inc = {1'b0, cnt_q} + 4'd1;
      reqf_d  = reqf_q;
      cnt_d   = 3'd0;
      if (req_s != reqf_q) begin
         if (cnt_inc >= FILT_L) begin
            reqf_d = req_s;
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   assign reqf_rise = reqf_d & ~reqf_q;

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      ack_d   = ack_q;
      abort_d = 1'b0;
      q_d     = q_q;
      case (state_q)
         IDLE: begin
            if (reqf_rise) begin
               q_d     = D;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Handshake takes priority over a simultaneous request withdrawal.
            if (valid_q && READY) begin
               valid_d = 1'b0;
               ack_d   = 1'b1;
               state_d = ACKH;
            end else if (!reqf_d) begin
               valid_d = 1'b0;
               abort_d = 1'b1;
               state_d = IDLE;
            end
         end
         ACKH: begin
            if (!reqf_d) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            ack_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         sync_q  <= '0;
         reqf_q  <= 1'b0;
         cnt_q   <= 3'd0;
         state_q <= IDLE;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         abort_q <= 1'b0;
         q_q     <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], REQ};
         reqf_q  <= reqf_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         valid_q <= valid_d;
         ack_q   <= ack_d;
         abort_q <= abort_d;
         q_q     <= q_d;
      end
   end

   assign VALID = valid_q;
   assign ACK   = ack_q;
   assign ABORT = abort_q;
   assign Q     = q_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_lshifdn_hsrx.sv
// Directed and randomized bench; the reference model works from a window over the sampled REQ history.
module tb_gf180mcu_osu_sc_12t_lshifdn_hsrx;

   localparam int W = 8;
   localparam int S = 2;
   localparam int F = 2;

   logic         CLK = 1'b0;
   logic         RN;
   logic         REQ;
   logic [W-1:0] D;
   logic         ACK;
   logic         VALID;
   logic         READY;
   logic [W-1:0] Q;
   logic         ABORT;

   int n_vec = 0;
   int n_err = 0;

   int           m_mode;   // 0 idle, 1 holding data, 2 acknowledging
   bit           m_reqf;
   bit           m_abort;
   logic [W-1:0] m_q;
   bit           rq[$];    // REQ as seen at each clock edge, oldest first

   gf180mcu_osu_sc_12t_lshifdn_hsrx #(
      .WIDTH(W), .SYNC_STAGES(S), .FILT(F)
   ) dut (
      .CLK(CLK), .RN(RN), .REQ(REQ), .D(D), .ACK(ACK), .VALID(VALID),
      .READY(READY), .Q(Q), .ABORT(ABORT)
   );

   always #5 CLK = ~CLK;

   function void m_reset();
      rq.delete();
      for (int i = 0; i < S + F; i++) rq.push_back(1'b0);
      m_mode  = 0;
      m_reqf  = 1'b0;
      m_abort = 1'b0;
      m_q     = '0;
   endfunction

   // Synced sample seen by the filter at edge n is REQ from S edges earlier;
   // a level is accepted once the last F such samples all show it.
   function void m_edge(bit r, logic [W-1:0] d, bit rdy);
      bit all_new, nf;
      rq.push_back(r);
      if (rq.size() > S + F) void'(rq.pop_front());
      all_new = 1'b1;
      for (int k = 0; k < F; k++)
         if (rq[rq.size() - 1 - S - k] == m_reqf) all_new = 1'b0;
      nf      = all_new ? ~m_reqf : m_reqf;
      m_abort = 1'b0;
      if (m_mode == 0) begin
         if (nf && !m_reqf) begin
            m_q    = d;
            m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (rdy) m_mode = 2;
         else if (!nf) begin
            m_mode  = 0;
            m_abort = 1'b1;
         end
      end else begin
         if (!nf) m_mode = 0;
      end
      m_reqf = nf;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      if (RN) m_edge(REQ, D, READY);
      else m_reset();
      #1;
      chk("valid", 32'(VALID), 32'(m_mode == 1));
      chk("ack",   32'(ACK),   32'(m_mode == 2));
      chk("abort", 32'(ABORT), 32'(m_abort));
      chk("q",     32'(Q),     32'(m_q));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      RN = 1'b0; REQ = 1'b0; READY = 1'b0; D = '0;
      m_reset();
      #3;
      chk("rst_valid", 32'(VALID), 32'd0);
      chk("rst_ack",   32'(ACK),   32'd0);
      chk("rst_abort", 32'(ABORT), 32'd0);
      chk("rst_q",     32'(Q),     32'd0);
      tick();
      RN = 1'b1;
      ticks(3);

      // Basic transfer with consumer already ready
      REQ = 1'b1; D = 8'hA5; READY = 1'b1;
      ticks(3);
      chk("lat_early", 32'(VALID), 32'd0);
      tick();
      chk("lat_valid", 32'(VALID), 32'd1);
      chk("lat_q",     32'(Q),     32'hA5);
      tick();
      chk("ack_rise",  32'(ACK),   32'd1);
      ticks(2);
      REQ = 1'b0; READY = 1'b0;
      ticks(3);
      chk("ack_hold",  32'(ACK),   32'd1);
      tick();
      chk("ack_fall",  32'(ACK),   32'd0);
      ticks(3);

      // Consumer stalls for 10 cycles
      REQ = 1'b1; D = 8'h5A;
      ticks(4);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_valid", 32'(VALID), 32'd1);
         chk("stall_q",     32'(Q),     32'h5A);
         chk("stall_ack",   32'(ACK),   32'd0);
      end
      READY = 1'b1;
      tick();
      chk("rdy_valid", 32'(VALID), 32'd0);
      chk("rdy_ack",   32'(ACK),   32'd1);
      REQ = 1'b0; READY = 1'b0;
      ticks(6);

      // One-cycle REQ glitch is filtered out
      REQ = 1'b1; D = 8'hFF;
      tick();
      REQ = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("glitch_busy", 32'(VALID | ACK | ABORT), 32'd0);
         chk("glitch_q",    32'(Q), 32'h5A);
      end

      // Request withdrawn while data still pending
      REQ = 1'b1; D = 8'h3C;
      ticks(6);
      REQ = 1'b0;
      ticks(3);
      chk("abort_early", 32'(ABORT), 32'd0);
      tick();
      chk("abort_pulse", 32'(ABORT), 32'd1);
      chk("abort_valid", 32'(VALID), 32'd0);
      chk("abort_ack",   32'(ACK),   32'd0);
      tick();
      chk("abort_end",   32'(ABORT), 32'd0);
      chk("abort_q",     32'(Q),     32'h3C);
      ticks(3);

      // Asynchronous reset mid-transfer, REQ kept high
      REQ = 1'b1; D = 8'h77;
      ticks(5);
      #3;
      RN = 1'b0;
      m_reset();
      #1;
      chk("arst_valid", 32'(VALID), 32'd0);
      chk("arst_q",     32'(Q),     32'd0);
      chk("arst_abort", 32'(ABORT), 32'd0);
      #1;
      RN = 1'b1;
      ticks(3);
      chk("recap_early", 32'(VALID), 32'd0);
      tick();
      chk("recap_valid", 32'(VALID), 32'd1);
      chk("recap_q",     32'(Q),     32'h77);
      READY = 1'b1;
      tick();
      REQ = 1'b0; READY = 1'b0;
      ticks(6);

      // READY arrives on the very edge the filtered request falls
      REQ = 1'b1; D = 8'hC3;
      ticks(6);
      REQ = 1'b0;
      ticks(3);
      READY = 1'b1;
      tick();
      chk("race_ack",   32'(ACK),   32'd1);
      chk("race_abort", 32'(ABORT), 32'd0);
      READY = 1'b0;
      tick();
      chk("race_ackclr", 32'(ACK),  32'd0);
      chk("race_abort2", 32'(ABORT), 32'd0);
      ticks(3);

      // Randomized traffic, glitches and occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(4) == 0) begin
            if (!REQ) D = W'($urandom);
            REQ = ~REQ;
         end
         READY = ($urandom_range(2) == 0);
         if ($urandom_range(149) == 0) begin
            #2;
            RN = 1'b0;
            m_reset();
            #1;
            chk("rnd_rst_valid", 32'(VALID), 32'd0);
            chk("rnd_rst_q",     32'(Q),     32'd0);
            RN = 1'b1;
         end
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
